// File: rtl/pulpemu_rst_pkg.sv
// Shared types and constants for the FPGA emulation reset sequencer.
// State encodings are visible on state_o, so their values are fixed.
package pulpemu_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_HYPER_RST  = 3'd1,
    ST_HYPER_WAIT = 3'd2,
    ST_SOC_HOLD   = 3'd3,
    ST_RUN        = 3'd4
  } rst_state_e;

  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned CAUSE_BTN  = 0;
  localparam int unsigned CAUSE_TRST = 1;
  localparam int unsigned CAUSE_LOCK = 2;
  localparam int unsigned CAUSE_SOFT = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulpemu_rst_debounce.sv
// Multi-flop synchronizer with an optional consecutive-cycle debounce filter.
// DEBOUNCE_CYCLES <= 1 exposes the raw synchronized level with no extra delay.
module pulpemu_rst_debounce
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_sync_only
      assign level_o = sync_q[SYNC_STAGES-1];
    end else begin : g_debounce
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;

      // Counter tracks how long the synced value has disagreed with the level.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[SYNC_STAGES-1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q   <= '0;
          level_q <= RESET_VAL;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign level_o = level_q;
    end
  endgenerate

endmodule

// File: rtl/pulpemu_rst_seq.sv
// Reset sequencer: conditions button/TRST/lock and releases HyperRAM, then
// the SoC, in a fixed order; supports a core-only soft reset from RUN.
module pulpemu_rst_seq
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned HYPER_RST_CYCLES  = 20,
  parameter int unsigned HYPER_WAIT_CYCLES = 40,
  parameter int unsigned SOC_HOLD_CYCLES   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pad_reset_i,
  input  logic               jtag_trst_ni,
  input  logic               clk_locked_i,
  input  logic               sw_reset_req_i,
  output logic               soc_rst_no,
  output logic               hyper_rst_no,
  output logic               ready_o,
  output logic [2:0]         state_o,
  output logic [CAUSE_W-1:0] reset_cause_o
);

  localparam int unsigned MAX_CYC = max3(HYPER_RST_CYCLES, HYPER_WAIT_CYCLES, SOC_HOLD_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOAD_HR = CNT_W'(HYPER_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_HW = CNT_W'(HYPER_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_SH = CNT_W'(SOC_HOLD_CYCLES - 1);

  logic btn_db, trst_s, lock_s, hard_req;

  pulpemu_rst_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)
  ) u_btn (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(pad_reset_i), .level_o(btn_db)
  );

  pulpemu_rst_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)
  ) u_trst (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(jtag_trst_ni), .level_o(trst_s)
  );

  pulpemu_rst_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)
  ) u_lock (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(clk_locked_i), .level_o(lock_s)
  );

  assign hard_req = btn_db | ~trst_s | ~lock_s;

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               soc_q, soc_d, hyper_q, hyper_d, ready_q, ready_d;

  // One down-counter serves every timed state; it is reloaded on each entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (!hard_req) begin
          state_d = ST_HYPER_RST;
          cnt_d   = LOAD_HR;
        end
      end
      ST_HYPER_RST: begin
        if (hard_req) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = ST_HYPER_WAIT;
          cnt_d   = LOAD_HW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HYPER_WAIT: begin
        if (hard_req) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = ST_SOC_HOLD;
          cnt_d   = LOAD_SH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SOC_HOLD: begin
        if (hard_req) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (hard_req) begin
          state_d             = ST_WAIT_LOCK;
          cause_d             = '0;
          cause_d[CAUSE_BTN]  = btn_db;
          cause_d[CAUSE_TRST] = ~trst_s;
          cause_d[CAUSE_LOCK] = ~lock_s;
        end else if (sw_reset_req_i) begin
          state_d             = ST_SOC_HOLD;
          cnt_d               = LOAD_SH;
          cause_d             = '0;
          cause_d[CAUSE_SOFT] = 1'b1;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    soc_d   = (state_d == ST_RUN);
    ready_d = (state_d == ST_RUN);
    hyper_d = (state_d == ST_HYPER_WAIT) || (state_d == ST_SOC_HOLD) || (state_d == ST_RUN);
  end

  // Outputs come straight from flops decoded off the next state, so they
  // switch on the same edge as the state register and cannot glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      cause_q <= '0;
      soc_q   <= 1'b0;
      hyper_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      soc_q   <= soc_d;
      hyper_q <= hyper_d;
      ready_q <= ready_d;
    end
  end

  assign soc_rst_no    = soc_q;
  assign hyper_rst_no  = hyper_q;
  assign ready_o       = ready_q;
  assign state_o       = state_q;
  assign reset_cause_o = cause_q;

endmodule
